// File: rtl/rx_frame_parser_pkg.sv
// Shared definitions for the serial frame parser: FSM encoding, framing constants and
// parameter defaults.
package rx_frame_parser_pkg;

    typedef enum logic [2:0] {
        StHunt    = 3'd0,
        StLen     = 3'd1,
        StPayload = 3'd2,
        StCrc     = 3'd3,
        StCheck   = 3'd4
    } state_e;

    localparam logic [7:0]  SYNC_BYTE            = 8'h7E;
    localparam logic [7:0]  CRC_POLY             = 8'h07;
    localparam int unsigned MAX_LEN_DEFAULT      = 16;
    localparam int unsigned IDLE_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/rx_frame_parser_crc8.sv
// Bit-serial CRC-8, MSB-first, zero init, no final XOR. Clear has priority over enable.
module crc8_serial
    import rx_frame_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       data_in,
    input  logic       enable,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q, crc_d;
    logic       feedback;

    always_comb begin
        feedback = crc_q[7] ^ data_in;
        crc_d    = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (enable) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/rx_frame_parser.sv
// Serial frame receiver: hunts for 0x7E, then parses LEN, payload and CRC-8 bit by bit,
// emitting payload bytes and a per-frame pass/fail verdict.
module rx_frame_parser
    import rx_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN      = MAX_LEN_DEFAULT,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int unsigned LenW  = $clog2(MAX_LEN + 1);
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [7:0]        hunt_q, hunt_d;
    logic [7:0]        data_q, data_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [LenW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;

    logic              in_frame;
    logic              crc_clear;
    logic              crc_en;
    logic              byte_end;
    logic [7:0]        byte_val;
    logic [7:0]        hunt_next;
    logic [7:0]        crc_out;

    crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (~rst),
        .clear   (crc_clear),
        .data_in (rx_bit),
        .enable  (crc_en),
        .crc_out (crc_out)
    );

    always_comb begin
        state_d      = state_q;
        hunt_d       = hunt_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        idle_d       = idle_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        crc_clear    = 1'b0;

        in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StCrc);
        crc_en    = in_frame && rx_valid;
        byte_val  = {data_q[6:0], rx_bit};
        byte_end  = crc_en && (bit_cnt_q == 3'd7);
        hunt_next = {hunt_q[6:0], rx_bit};

        if (in_frame) begin
            if (rx_valid) begin
                data_d    = byte_val;
                bit_cnt_d = bit_cnt_q + 3'd1;
                idle_d    = '0;
            end else if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
                frame_err_d = 1'b1;
                idle_d      = '0;
                state_d     = StHunt;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end

        unique case (state_q)
            StHunt: begin
                if (rx_valid) begin
                    hunt_d = hunt_next;
                    if (hunt_next == SYNC_BYTE) begin
                        hunt_d     = 8'h00;
                        crc_clear  = 1'b1;
                        bit_cnt_d  = 3'd0;
                        data_d     = 8'h00;
                        byte_cnt_d = '0;
                        idle_d     = '0;
                        state_d    = StLen;
                    end
                end
            end
            StLen: begin
                if (byte_end) begin
                    if (byte_val == 8'h00 || 32'(byte_val) > MAX_LEN) begin
                        frame_err_d = 1'b1;
                        state_d     = StHunt;
                    end else begin
                        len_d      = LenW'(byte_val);
                        byte_cnt_d = '0;
                        state_d    = StPayload;
                    end
                end
            end
            StPayload: begin
                if (byte_end) begin
                    byte_out_d   = byte_val;
                    byte_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + LenW'(1);
                    if (byte_cnt_d == len_q) begin
                        state_d = StCrc;
                    end
                end
            end
            StCrc: begin
                if (byte_end) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // The hunt register is already zero here, so a bit arriving now starts resync.
                if (rx_valid) begin
                    hunt_d = hunt_next;
                end
                frame_done_d = 1'b1;
                frame_ok_d   = (crc_out == 8'h00);
                frame_err_d  = (crc_out != 8'h00);
                state_d      = StHunt;
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StHunt;
            hunt_q       <= 8'h00;
            data_q       <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            idle_q       <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hunt_q       <= hunt_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            idle_q       <= idle_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: expected output events are queued as stimulus is
// driven and matched by a negedge monitor.
module tb_rx_frame_parser;

    localparam logic [1:0] EvByte = 2'd0;
    localparam logic [1:0] EvDone = 2'd1;
    localparam logic [1:0] EvErr  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_bit = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_done;
    logic       frame_ok;
    logic       frame_err;

    int   vectors = 0;
    int   fails   = 0;
    ev_t  exp_q[$];

    rx_frame_parser dut (
        .clk        (clk),
        .rst        (rst),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [7:0] data, input string tag);
        ev_t e;
        vectors++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL %s: unexpected event kind=%0d data=%02h, expected none", tag, kind, data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert ({kind, data} === {e.kind, e.data}) else begin
                fails++;
                $error("FAIL %s: got kind=%0d data=%02h, expected kind=%0d data=%02h",
                       tag, kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) check_ev(EvByte, byte_out, "byte");
            if (frame_done) begin
                check_ev(EvDone, {7'b0, frame_ok}, "done");
                vectors++;
                assert (frame_err === ~frame_ok) else begin
                    fails++;
                    $error("FAIL done_err: frame_err=%b, expected %b", frame_err, ~frame_ok);
                end
            end else if (frame_err) begin
                check_ev(EvErr, 8'h00, "err");
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_bit   = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bit(input logic obs, input logic exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        assert (exp_q.size() === 0) else begin
            fails++;
            $error("FAIL %s: %0d expected events never seen, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        vectors++;
        assert ({byte_out, byte_valid, frame_done, frame_ok, frame_err} === 12'h000) else begin
            fails++;
            $error("FAIL %s: outputs=%03h, expected 000", tag,
                   {byte_out, byte_valid, frame_done, frame_ok, frame_err});
        end
    endtask

    task automatic good_frame(input int gap);
        push_ev(EvByte, 8'h00);
        push_ev(EvDone, 8'h01);
        send_byte(8'h7E, gap);
        send_byte(8'h01, gap);
        send_byte(8'h00, gap);
        send_byte(8'h15, gap);
        idle(4);
    endtask

    initial begin
        idle(3);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        idle(3);

        // Contiguous good frame, with latency checks on byte_valid and frame_done.
        push_ev(EvByte, 8'h00);
        push_ev(EvDone, 8'h01);
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        check_bit(byte_valid, 1'b1, "byte_valid_latency");
        send_byte(8'h15, 0);
        check_bit(frame_done, 1'b0, "done_not_early");
        idle(1);
        check_bit(frame_done, 1'b1, "done_latency");
        check_bit(frame_ok, 1'b1, "ok_latency");
        idle(4);
        check_drained("good_frame");

        // Bad CRC.
        push_ev(EvByte, 8'h00);
        push_ev(EvDone, 8'h00);
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h14, 0);
        idle(4);
        check_drained("bad_crc");

        // Zero and oversize lengths.
        push_ev(EvErr, 8'h00);
        send_byte(8'h7E, 0);
        send_byte(8'h00, 0);
        idle(3);
        check_drained("len_zero");
        push_ev(EvErr, 8'h00);
        send_byte(8'h7E, 0);
        send_byte(8'h11, 0);
        idle(3);
        check_drained("len_over");

        // Good frame with gaps between bits.
        good_frame(3);
        check_drained("gapped_frame");

        // Idle timeout mid-payload, then recovery.
        push_ev(EvErr, 8'h00);
        send_byte(8'h7E, 0);
        send_byte(8'h02, 0);
        idle(63);
        check_bit(frame_err, 1'b0, "timeout_not_early");
        idle(1);
        check_bit(frame_err, 1'b1, "timeout_err");
        idle(3);
        check_drained("timeout");
        good_frame(0);
        check_drained("after_timeout");

        // Reset mid-frame abandons it silently.
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        idle(2);
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        idle(80);
        check_drained("after_reset");
        good_frame(0);
        check_drained("post_reset_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
